keypad_scanner: RTL and testbench

Input-side counterpart of the Basys 7-segment display driver: scans a 4x4 matrix keypad (PmodKYPD-style) by driving one column low at a time and sensing the rows. Debounces the key, rejects multi-key ghosts, emits a one-cycle key event, and shifts each accepted hex digit into a 16-bit entry register. That register feeds the pipeline's register-load path or the display for operator data entry.

---
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, 2-flop row sync, ghost reject, scan-level debounce, hex entry register.
// Latency: key_valid one cycle after the scan_done of the DEBOUNCE-th agreeing scan.
// Backpressure: none; key_valid is a one-cycle pulse with no ready, and key_code/value hold between pulses.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_row[3:0]   keypad rows, active-low, asynchronous to i_clk
//   i_clear      synchronous clear of o_value
//   o_col[3:0]   column drive, active-low, exactly one bit low
//   o_key_valid  one-cycle pulse per accepted press
//   o_key_code   hex code of the last accepted key
//   o_pressed    high while an accepted key is considered held
//   o_value      last four accepted digits, newest in [3:0]
module keypad_scanner #(
    parameter int SCAN_DIV = 25000,
    parameter int DEBOUNCE = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_row,
    input  logic        i_clear,
    output logic [3:0]  o_col,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output logic        o_pressed,
    output logic [15:0] o_value
);
    localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DB_TARGET  = 4'(DEBOUNCE);

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_PRESS_CHK   = 2'd1;
    localparam logic [1:0] S_HELD        = 2'd2;
    localparam logic [1:0] S_RELEASE_CHK = 2'd3;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // scan datapath registers
    logic [3:0]    r_row_s1, r_row_s2;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col_idx;
    logic [1:0]    r_hits;      // low bits seen this scan: 0, 1, or 2 meaning "two or more"
    logic [3:0]    r_code;

    // debounce / output registers
    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [3:0]    r_cand;
    logic          r_key_valid;
    logic [3:0]    r_key_code;
    logic [15:0]   r_value;

    logic [3:0]    w_low;
    logic [2:0]    w_col_cnt;
    logic [2:0]    w_sum;
    logic [1:0]    w_hits_next;
    logic [1:0]    w_row_idx;
    logic [3:0]    w_code_next;
    logic          w_sample;
    logic          w_scan_done;
    logic          w_scan_key;

    assign w_low     = ~r_row_s2;
    assign w_col_cnt = 3'(w_low[0]) + 3'(w_low[1]) + 3'(w_low[2]) + 3'(w_low[3]);
    assign w_sum     = {1'b0, r_hits} + w_col_cnt;
    // saturate at 2: anything beyond one hit is already a ghost
    assign w_hits_next = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

    always_comb begin
        w_row_idx = 2'd3;
        if (w_low[0])      w_row_idx = 2'd0;
        else if (w_low[1]) w_row_idx = 2'd1;
        else if (w_low[2]) w_row_idx = 2'd2;
    end

    assign w_code_next = (w_col_cnt == 3'd1) ? keymap(w_row_idx, r_col_idx) : r_code;
    assign w_sample    = (r_dwell == DWELL_LAST);
    assign w_scan_done = w_sample && (r_col_idx == 2'd3);
    assign w_scan_key  = (w_hits_next == 2'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_row_s1  <= 4'b1111;
            r_row_s2  <= 4'b1111;
            r_dwell   <= '0;
            r_col_idx <= 2'd0;
            r_hits    <= 2'd0;
            r_code    <= 4'h0;
        end else begin
            r_row_s1 <= i_row;
            r_row_s2 <= r_row_s1;
            if (w_sample) begin
                r_dwell   <= '0;
                r_col_idx <= r_col_idx + 2'd1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
            // the col3 sample closes the scan; the accumulator restarts for the next one
            if (w_scan_done) begin
                r_hits <= 2'd0;
                r_code <= 4'h0;
            end else if (w_sample) begin
                r_hits <= w_hits_next;
                r_code <= w_code_next;
            end
        end
    end

    logic [1:0] w_state_nx;
    logic [3:0] w_cnt_nx;
    logic [3:0] w_cand_nx;
    logic       w_accept;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        if (w_scan_done) begin
            case (r_state)
                S_IDLE: begin
                    if (w_scan_key) begin
                        w_cand_nx = w_code_next;
                        w_cnt_nx  = 4'd1;
                        if (DB_TARGET == 4'd1) begin
                            w_accept   = 1'b1;
                            w_state_nx = S_HELD;
                        end else begin
                            w_state_nx = S_PRESS_CHK;
                        end
                    end
                end
                S_PRESS_CHK: begin
                    if (!w_scan_key) begin
                        w_state_nx = S_IDLE;
                    end else if (w_code_next == r_cand) begin
                        w_cnt_nx = r_cnt + 4'd1;
                        if (r_cnt + 4'd1 == DB_TARGET) begin
                            w_accept   = 1'b1;
                            w_state_nx = S_HELD;
                        end
                    end else begin
                        w_cand_nx = w_code_next;
                        w_cnt_nx  = 4'd1;
                    end
                end
                S_HELD: begin
                    // no auto-repeat: any key, even a different one, just keeps us here
                    if (!w_scan_key) begin
                        w_cnt_nx   = 4'd1;
                        w_state_nx = (DB_TARGET == 4'd1) ? S_IDLE : S_RELEASE_CHK;
                    end
                end
                default: begin
                    if (w_scan_key) begin
                        w_state_nx = S_HELD;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                        if (r_cnt + 4'd1 == DB_TARGET) w_state_nx = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_cand      <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_value     <= 16'h0000;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_cand      <= w_cand_nx;
            r_key_valid <= w_accept;
            if (w_accept) r_key_code <= w_cand_nx;
            // clear has priority over a simultaneous accept for the entry register only
            if (i_clear)       r_value <= 16'h0000;
            else if (w_accept) r_value <= {r_value[11:0], w_cand_nx};
        end
    end

    assign o_col       = ~(4'b0001 << r_col_idx);
    assign o_key_valid = r_key_valid;
    assign o_key_code  = r_key_code;
    assign o_pressed   = (r_state == S_HELD) || (r_state == S_RELEASE_CHK);
    assign o_value     = r_value;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 (one scan = 16 cycles).
// Latency expectations are counted in cycles since reset release (cyc); scan_done falls on cyc%16==15.
// Backpressure: none; a keypad model pulls row[r] low only while col[c] is low for each held key.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        kv;
    logic [3:0]  kc;
    logic        pressed;
    logic [15:0] value;
    logic [15:0] keys;          // bit r*4+c set = key at row r, col c held

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_pulse = 0;
    int last_pulse = -1;
    logic prev_kv = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .i_clk(clk), .i_reset(rst), .i_row(row), .i_clear(clear),
        .o_col(col), .o_key_valid(kv), .o_key_code(kc),
        .o_pressed(pressed), .o_value(value)
    );

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pulse counter and width check
    always @(negedge clk) begin
        if (kv === 1'b1) begin
            n_pulse++;
            last_pulse = cyc;
            chk("kv_not_consecutive", {31'd0, prev_kv}, 32'd0);
        end
        prev_kv = kv;
    end

    logic [3:0] exp_col [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int         dig_bit [5] = '{0, 1, 2, 3, 5};
    logic [3:0] dig_code[5] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h5};
    int base;
    int p0;

    initial begin
        rst = 1'b1; clear = 1'b0; keys = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset values and free-running column scan
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_kv", 32'(kv), 32'd0);
        chk("rst_kc", 32'(kc), 32'd0);
        chk("rst_pressed", 32'(pressed), 32'd0);
        chk("rst_value", 32'(value), 32'd0);
        for (int k = 0; k < 20; k++) begin
            chk("col_step", 32'(col), 32'(exp_col[(k/4)%4]));
            @(negedge clk);
        end
        repeat (28) @(negedge clk);
        chk("idle_no_pulse", n_pulse, 0);
        chk("idle_pressed", 32'(pressed), 32'd0);

        // 2: key '6' (r1/c2) held 6 scans from a scan boundary, then released
        base = cyc;
        keys = 16'h0040;
        repeat (47) @(negedge clk);
        chk("k6_kv_before", 32'(kv), 32'd0);
        @(negedge clk);
        chk("k6_kv", 32'(kv), 32'd1);
        chk("k6_code", 32'(kc), 32'h6);
        chk("k6_value", 32'(value), 32'h0006);
        chk("k6_pressed_rise", 32'(pressed), 32'd1);
        @(negedge clk);
        chk("k6_kv_width", 32'(kv), 32'd0);
        repeat (47) @(negedge clk);
        chk("k6_one_pulse", n_pulse, 1);
        chk("k6_pulse_cycle", last_pulse, base + 48);
        chk("k6_pressed_held", 32'(pressed), 32'd1);
        keys = 16'h0000;
        repeat (47) @(negedge clk);
        chk("k6_pressed_before_fall", 32'(pressed), 32'd1);
        @(negedge clk);
        chk("k6_pressed_fall", 32'(pressed), 32'd0);

        // 3: bouncy '1': 2 scans on, 1 off, 2 on -> never qualifies
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        p0 = n_pulse;
        keys = 16'h0001; repeat (32) @(negedge clk);
        keys = 16'h0000; repeat (16) @(negedge clk);
        keys = 16'h0001; repeat (32) @(negedge clk);
        keys = 16'h0000; repeat (64) @(negedge clk);
        chk("bounce_no_pulse", n_pulse, p0);
        chk("bounce_value", 32'(value), 32'd0);
        chk("bounce_pressed", 32'(pressed), 32'd0);

        // 4: enter 1,2,3,A,5
        for (int i = 0; i < 5; i++) begin
            keys = 16'h0001 << dig_bit[i];
            repeat (64) @(negedge clk);
            chk("entry_code", 32'(kc), 32'(dig_code[i]));
            chk("entry_pressed", 32'(pressed), 32'd1);
            keys = 16'h0000;
            repeat (64) @(negedge clk);
            chk("entry_released", 32'(pressed), 32'd0);
        end
        chk("entry_pulses", n_pulse, p0 + 5);
        chk("entry_value", 32'(value), 32'h23A5);
        chk("entry_last_code", 32'(kc), 32'h5);

        // 5: ghost (r0/c1 + r2/c3) rejected, then '7' with clear in its key_valid cycle
        keys = 16'h0802;
        repeat (96) @(negedge clk);
        chk("ghost_no_pulse", n_pulse, p0 + 5);
        chk("ghost_pressed", 32'(pressed), 32'd0);
        chk("ghost_value", 32'(value), 32'h23A5);
        keys = 16'h0000;
        repeat (16) @(negedge clk);
        keys = 16'h0100;
        repeat (48) @(negedge clk);
        chk("k7_kv", 32'(kv), 32'd1);
        chk("k7_value_shift", 32'(value), 32'h3A57);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_value", 32'(value), 32'd0);
        chk("clear_code", 32'(kc), 32'h7);
        repeat (15) @(negedge clk);
        keys = 16'h0000;
        repeat (64) @(negedge clk);
        chk("k7_released", 32'(pressed), 32'd0);

        // 6: reset while '9' (r2/c2) is held; must re-qualify from IDLE
        keys = 16'h0400;
        repeat (64) @(negedge clk);
        chk("k9_held", 32'(pressed), 32'd1);
        chk("k9_value", 32'(value), 32'h0009);
        p0 = n_pulse;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_col", 32'(col), 32'hE);
        chk("mid_rst_kv", 32'(kv), 32'd0);
        chk("mid_rst_kc", 32'(kc), 32'd0);
        chk("mid_rst_pressed", 32'(pressed), 32'd0);
        chk("mid_rst_value", 32'(value), 32'd0);
        repeat (47) @(negedge clk);
        chk("requal_kv_before", 32'(kv), 32'd0);
        @(negedge clk);
        chk("requal_kv", 32'(kv), 32'd1);
        chk("requal_code", 32'(kc), 32'h9);
        chk("requal_value", 32'(value), 32'h0009);
        chk("requal_pressed", 32'(pressed), 32'd1);
        repeat (20) @(negedge clk);
        chk("requal_one_pulse", n_pulse, p0 + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
